// File: rtl/sync_fifo_pkg.sv
// Shared constants and parameter-legality helpers for the flexible single-clock FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AF    = 6;
  localparam int DEF_AE    = 2;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2_f(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok_f(input int width, input int depth,
                                     input int af, input int ae);
    return (width >= 1) && is_pow2_f(depth) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// FIFO bus: write/read requests from the user side, data and status back from the FIFO.
// Handshake: wr_en/rd_en are requests; the FIFO accepts them unless full/empty refuses, rd_valid marks fresh rd_data.
interface sync_fifo_flex_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = clog2_f(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port; the array itself is not reset.
module sync_fifo_mem #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register holds its value when no read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with registered status flags and occupancy count.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF,
  parameter int AE_LEVEL = DEF_AE
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_flex_if.slave  bus
);
  localparam int AW = clog2_f(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!params_ok_f(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_flex: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wa, ra;
  logic [WIDTH-1:0] rdata;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wa = bus.wr_en & (~full_q | bus.rd_en);
  assign ra = bus.rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(wa);
    rd_ptr_d   = rd_ptr_q + PW'(ra);
    count_d    = count_q + CW'(wa) - CW'(ra);
    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == '0);
    af_d       = (count_d >= AF_C);
    ae_d       = (count_d <= AE_C);
    rd_valid_d = ra;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wa),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.wr_data),
    .re    (ra),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.rd_data      = rdata;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.wr_en & ~wa);
    unf_d = unf_q | (bus.rd_en & ~ra);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex (WIDTH=6, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo_flex;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [5:0] exp_q[$];

  sync_fifo_flex_if #(.WIDTH(6), .DEPTH(8)) bus ();

  sync_fifo_flex #(.WIDTH(6), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    rst_n = 1'b0;
    #13;
    rst_n = 1'b1;
    step();
    exp_q.delete();
  endtask

  // driver: one write (and optionally a read) per cycle, expected entries tracked in exp_q
  task automatic push(input logic [5:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d; bus.rd_en = 1'b0;
    exp_q.push_back(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pop_check(input string name, input int exp_cnt);
    logic [5:0] e;
    e = exp_q.pop_front();
    bus.rd_en = 1'b1; bus.wr_en = 1'b0;
    step();
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || bus.count !== 4'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL %s: rd_valid=%0b rd_data=%0h count=%0d, required 1/%0h/%0d",
               name, bus.rd_valid, bus.rd_data, bus.count, e, exp_cnt);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 4'd0 ||
        bus.rd_data !== 6'd0 || bus.rd_valid !== 1'b0 || bus.almost_empty !== 1'b1 ||
        bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: e=%0b f=%0b cnt=%0d rd=%0h v=%0b ae=%0b af=%0b ovf=%0b unf=%0b, required 1 0 0 0 0 1 0 0 0",
               bus.empty, bus.full, bus.count, bus.rd_data, bus.rd_valid,
               bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      push(6'(i));
      tests_run++;
      if (bus.count !== 4'(i) || bus.full !== (i == 8) || bus.almost_full !== (i >= 6) ||
          bus.almost_empty !== (i <= 2) || bus.empty !== 1'b0) begin
        tests_failed++;
        $display("FAIL fill[%0d]: cnt=%0d f=%0b af=%0b ae=%0b e=%0b, required %0d %0b %0b %0b 0",
                 i, bus.count, bus.full, bus.almost_full, bus.almost_empty, bus.empty,
                 i, i == 8, i >= 6, i <= 2);
      end
    end
    for (int i = 1; i <= 8; i++) pop_check("drain", 8 - i);
    step();
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 6'h08 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_idle: v=%0b rd=%0h e=%0b f=%0b, required 0 08 1 0",
               bus.rd_valid, bus.rd_data, bus.empty, bus.full);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 5; i++) push(6'(8'h10 + i));
    for (int i = 0; i < 5; i++) pop_check("wrap_a", 4 - i);
    for (int i = 0; i < 8; i++) push(6'(8'h20 + i));
    tests_run++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      tests_failed++;
      $display("FAIL wrap_full: f=%0b cnt=%0d, required 1 8", bus.full, bus.count);
    end
    for (int i = 0; i < 8; i++) pop_check("wrap_b", 7 - i);
  endtask

  task automatic test_full_rw();
    apply_reset();
    for (int i = 0; i < 8; i++) push(6'(8'h30 + i));
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 6'h2A;
    step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(6'h2A);
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 6'h30 || bus.count !== 4'd8 || bus.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_rw: v=%0b rd=%0h cnt=%0d f=%0b, required 1 30 8 1",
               bus.rd_valid, bus.rd_data, bus.count, bus.full);
    end
    for (int i = 0; i < 8; i++) pop_check("full_rw_drain", 7 - i);
  endtask

  task automatic test_empty_rw();
    apply_reset();
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 6'h15;
    step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    exp_q.push_back(6'h15);
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 4'd1 || bus.empty !== 1'b0 || bus.rd_data !== 6'h00) begin
      tests_failed++;
      $display("FAIL empty_rw: v=%0b cnt=%0d e=%0b rd=%0h, required 0 1 0 00",
               bus.rd_valid, bus.count, bus.empty, bus.rd_data);
    end
    pop_check("empty_rw_read", 0);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) push(6'(8'h05 + i));
    apply_reset();
    tests_run++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data !== 6'h00) begin
      tests_failed++;
      $display("FAIL mid_reset: cnt=%0d e=%0b rd=%0h, required 0 1 00", bus.count, bus.empty, bus.rd_data);
    end
  endtask

  task automatic test_errors();
    apply_reset();
    for (int i = 0; i < 8; i++) push(6'(8'h08 + i));
    bus.wr_en = 1'b1; bus.wr_data = 6'h3F;
    step();
    bus.wr_en = 1'b0;
    tests_run++;
    if (bus.overflow !== ERR_ON || bus.count !== 4'd8 || bus.underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow: ovf=%0b cnt=%0d unf=%0b, required %0b 8 0",
               bus.overflow, bus.count, bus.underflow, ERR_ON);
    end
    for (int i = 0; i < 8; i++) pop_check("err_drain", 7 - i);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    step();
    tests_run++;
    if (bus.underflow !== ERR_ON || bus.overflow !== ERR_ON || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== 6'h0F || bus.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL underflow: unf=%0b ovf=%0b v=%0b rd=%0h cnt=%0d, required %0b %0b 0 0f 0",
               bus.underflow, bus.overflow, bus.rd_valid, bus.rd_data, bus.count, ERR_ON, ERR_ON);
    end
    apply_reset();
    tests_run++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_reset: ovf=%0b unf=%0b, required 0 0", bus.overflow, bus.underflow);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.wr_data  = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rw();
    test_empty_rw();
    test_mid_reset();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
